pocket_detector: RTL and testbench
==================================

POCKET_DETECTOR -- requirements
Module: pocket_detector

Interface
REQ-001 Parameter NUM_HOLES, default 6: number of hole drawing-request inputs.
REQ-002 Parameter OVERLAP_THRESHOLD, default 64: minimum ball/hole overlap pixels per frame for a hole to qualify.
REQ-003 Parameter CONFIRM_FRAMES, default 2, legal range 1..7: consecutive qualifying frames needed before a pocket is reported.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
REQ-007 drawingRequestBall  in  1  ball is drawing the current pixel; registered, cycle-aligned with hole requests.
REQ-008 drawingRequestHole  in  NUM_HOLES  bit i is the drawing request of hole instance i for the current pixel.
REQ-009 ballActive  in  1  ball is on the table; overlap is counted only while high.
REQ-010 pocketAck  in  1  game controller accepts the reported pocket event.
REQ-011 pocketReq  out  1  pocket event pending; held until acknowledged.
REQ-012 pocketHole  out  3  index of the pocketing hole; valid while pocketReq is high.

Function
REQ-013 One 11-bit saturating overlap counter per hole SHALL increment in every cycle where ballActive, drawingRequestBall and drawingRequestHole[i] are all 1; a counter at 2047 holds.
REQ-014 On a startOfFrame cycle, every counter SHALL be snapshotted and then cleared. The pixel sampled in that cycle SHALL count toward the new frame: the counter loads 1 if overlapping, otherwise 0.
REQ-015 Frame evaluation SHALL use the snapshot: the qualifying hole is the lowest index i with snapshot[i] >= OVERLAP_THRESHOLD. Ties SHALL resolve to the lowest index.
REQ-016 The FSM SHALL have exactly these states: TRACK, CANDIDATE, REPORT, WAIT_CLEAR.
REQ-017 TRACK: at evaluation, if hole h qualifies, the FSM SHALL latch candIdx=h and confirmCnt=1. It then goes to REPORT if CONFIRM_FRAMES==1, otherwise to CANDIDATE. If no hole qualifies, it stays in TRACK.
REQ-018 CANDIDATE, at evaluation:
- same hole qualifies: confirmCnt increments; on reaching CONFIRM_FRAMES the FSM goes to REPORT.
- a different hole qualifies: candIdx is replaced and confirmCnt=1; the FSM stays in CANDIDATE.
- no hole qualifies: the FSM returns to TRACK.
REQ-019 pocketReq SHALL be registered: it is high in every cycle the FSM is in REPORT, rising the cycle after the transition. pocketHole SHALL equal candIdx and stay stable while pocketReq is high.
REQ-020 pocketAck SHALL be honoured only while pocketReq is high. Ack then moves the FSM to WAIT_CLEAR, and pocketReq is low the next cycle. Ack in any other state is ignored.
REQ-021 In REPORT and WAIT_CLEAR, startOfFrame evaluations SHALL NOT change state or candIdx; counters keep running per REQ-013/014.
REQ-022 WAIT_CLEAR SHALL return to TRACK on the first cycle ballActive is 0.
REQ-023 startOfFrame together with pocketAck in REPORT: the ack wins, and the FSM goes to WAIT_CLEAR.
REQ-024 pocketHole SHALL be 0 whenever pocketReq is 0.

Reset
REQ-025 While reset is high, at each clock edge:
- state becomes TRACK;
- all counters, snapshots, candIdx and confirmCnt become 0;
- pocketReq and pocketHole become 0.
REQ-026 Reset asserted during REPORT SHALL drop pocketReq on the next clock edge with no event retained. Reset has priority over every other input.

Structure
REQ-027 Package pocket_pkg SHALL hold the state enum pocket_state_t, the counter width constant (11), and the hole-index width (3).
REQ-028 Sub-module overlap_counter SHALL implement one saturating per-hole counter with snapshot. It is instantiated NUM_HOLES times by a generate loop.
REQ-029 Target size: 150-300 lines of RTL in total.

Verification
REQ-030 Defaults. Ball overlaps hole 2 for 100 pixels/frame over 2 frames -> pocketReq=1, pocketHole=2 one cycle after the 3rd startOfFrame. It holds until pocketAck, then drops the next cycle.
REQ-031 Threshold edge. 63 overlap pixels per frame for 5 frames -> pocketReq stays 0. 64 pixels for 2 frames -> event reported.
REQ-032 Candidate switch and tie. Frame 1: hole 1 has 80 pixels. Frame 2: holes 3 and 4 each have 80 -> candIdx=3, confirmCnt=1. Frame 3: hole 3 has 80 -> pocketHole=3.
REQ-033 Handshake. pocketAck pulsed in TRACK -> no effect. In REPORT, ack coincides with startOfFrame -> WAIT_CLEAR. Then ballActive=0 for 1 cycle -> TRACK.
REQ-034 Reset mid-REPORT. Reset pulsed while pocketReq=1 -> pocketReq=0 and pocketHole=0 next edge. The following frame with 0 overlap yields no event.
REQ-035 Saturation. Overlap held for 3000 cycles within one frame -> snapshot reads 2047, with no wrap.

Source files
------------

// File: rtl/pocket_pkg.sv
// Purpose: shared types and widths for the pocket detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pocket_pkg;

   localparam int CNT_W  = 11;  // per-hole overlap counter width
   localparam int IDX_W  = 3;   // hole index width
   localparam int CONF_W = 3;   // confirm counter width (CONFIRM_FRAMES <= 7)

   typedef enum logic [1:0] {
      TRACK      = 2'd0,
      CANDIDATE  = 2'd1,
      REPORT     = 2'd2,
      WAIT_CLEAR = 2'd3
   } pocket_state_t;

endpackage

// File: rtl/overlap_counter.sv
// Purpose: saturating per-hole ball/hole overlap counter with per-frame snapshot.
// Latency: cnt reflects hits one cycle later; snap loads on the startOfFrame edge.
// Backpressure: none, counts every qualifying pixel.
// Ports: clk, reset (sync, active-high), start_of_frame, hit (overlapping pixel),
//        cnt (running count of the current frame), snap (count of the previous frame).
module overlap_counter
   import pocket_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start_of_frame,
   input  logic             hit,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] snap
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] snap_q, snap_d;

   always_comb begin
      cnt_d  = cnt_q;
      snap_d = snap_q;
      if (start_of_frame) begin
         // The frame just ended is captured; the pixel of this cycle already
         // belongs to the new frame.
         snap_d = cnt_q;
         cnt_d  = hit ? CNT_W'(1) : '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         snap_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
      end
   end

   assign cnt  = cnt_q;
   assign snap = snap_q;

endmodule

// File: rtl/pocket_detector.sv
// Purpose: detects a ball dropping into a hole from per-frame overlap counts.
// Latency: pocketReq rises one cycle after the confirming startOfFrame.
// Backpressure: pocketReq/pocketHole held until pocketAck is seen.
// Ports: clk, reset (sync, active-high), startOfFrame, drawingRequestBall,
//        drawingRequestHole[NUM_HOLES], ballActive, pocketAck -> pocketReq, pocketHole.
module pocket_detector
   import pocket_pkg::*;
#(
   parameter int NUM_HOLES         = 6,
   parameter int OVERLAP_THRESHOLD = 64,
   parameter int CONFIRM_FRAMES    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 startOfFrame,
   input  logic                 drawingRequestBall,
   input  logic [NUM_HOLES-1:0] drawingRequestHole,
   input  logic                 ballActive,
   input  logic                 pocketAck,
   output logic                 pocketReq,
   output logic [IDX_W-1:0]     pocketHole
);

   localparam logic [CNT_W-1:0]  THR      = CNT_W'(OVERLAP_THRESHOLD);
   localparam logic [CONF_W-1:0] CONF_TGT = CONF_W'(CONFIRM_FRAMES);

   logic [CNT_W-1:0] cur_cnt  [NUM_HOLES];
   logic [CNT_W-1:0] snap_cnt [NUM_HOLES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
         overlap_counter u_cnt (
            .clk            (clk),
            .reset          (reset),
            .start_of_frame (startOfFrame),
            .hit            (ballActive & drawingRequestBall & drawingRequestHole[gi]),
            .cnt            (cur_cnt[gi]),
            .snap           (snap_cnt[gi])
         );
      end
   endgenerate

   // Evaluation happens in the startOfFrame cycle itself, on the value being
   // written into each snapshot register, so the decision is not delayed a cycle.
   logic             qual_vld;
   logic [IDX_W-1:0] qual_idx;

   always_comb begin
      qual_vld = 1'b0;
      qual_idx = '0;
      // Scan high to low so the lowest qualifying index wins.
      for (int i = NUM_HOLES - 1; i >= 0; i--) begin
         if (cur_cnt[i] >= THR) begin
            qual_vld = 1'b1;
            qual_idx = IDX_W'(i);
         end
      end
   end

   pocket_state_t     state_q, state_d;
   logic [IDX_W-1:0]  cand_idx_q, cand_idx_d;
   logic [CONF_W-1:0] confirm_cnt_q, confirm_cnt_d;
   logic              pocket_req_q, pocket_req_d;
   logic [IDX_W-1:0]  pocket_hole_q, pocket_hole_d;

   always_comb begin
      state_d       = state_q;
      cand_idx_d    = cand_idx_q;
      confirm_cnt_d = confirm_cnt_q;

      unique case (state_q)
         TRACK: begin
            if (startOfFrame && qual_vld) begin
               cand_idx_d    = qual_idx;
               confirm_cnt_d = CONF_W'(1);
               state_d       = (CONF_TGT == CONF_W'(1)) ? REPORT : CANDIDATE;
            end
         end
         CANDIDATE: begin
            if (startOfFrame) begin
               if (!qual_vld) begin
                  state_d = TRACK;
               end else if (qual_idx == cand_idx_q) begin
                  confirm_cnt_d = confirm_cnt_q + CONF_W'(1);
                  if (confirm_cnt_d >= CONF_TGT) state_d = REPORT;
               end else begin
                  cand_idx_d    = qual_idx;
                  confirm_cnt_d = CONF_W'(1);
               end
            end
         end
         REPORT: begin
            // pocketReq is high exactly while in REPORT, so any ack here is valid;
            // frame evaluations are ignored.
            if (pocketAck) state_d = WAIT_CLEAR;
         end
         WAIT_CLEAR: begin
            if (!ballActive) state_d = TRACK;
         end
         default: state_d = TRACK;
      endcase

      pocket_req_d  = (state_d == REPORT);
      pocket_hole_d = pocket_req_d ? cand_idx_d : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= TRACK;
         cand_idx_q    <= '0;
         confirm_cnt_q <= '0;
         pocket_req_q  <= 1'b0;
         pocket_hole_q <= '0;
      end else begin
         state_q       <= state_d;
         cand_idx_q    <= cand_idx_d;
         confirm_cnt_q <= confirm_cnt_d;
         pocket_req_q  <= pocket_req_d;
         pocket_hole_q <= pocket_hole_d;
      end
   end

   assign pocketReq  = pocket_req_q;
   assign pocketHole = pocket_hole_q;

endmodule

// File: tb/tb_pocket_detector.sv
// Purpose: directed self-checking bench for pocket_detector with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_pocket_detector;
   import pocket_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       startOfFrame;
   logic       drawingRequestBall;
   logic [5:0] drawingRequestHole;
   logic       ballActive;
   logic       pocketAck;
   logic       pocketReq;
   logic [2:0] pocketHole;

   int checks = 0;
   int errors = 0;

   pocket_detector dut (
      .clk                (clk),
      .reset              (reset),
      .startOfFrame       (startOfFrame),
      .drawingRequestBall (drawingRequestBall),
      .drawingRequestHole (drawingRequestHole),
      .ballActive         (ballActive),
      .pocketAck          (pocketAck),
      .pocketReq          (pocketReq),
      .pocketHole         (pocketHole)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      startOfFrame       = 1'b0;
      drawingRequestBall = 1'b0;
      drawingRequestHole = '0;
      pocketAck          = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      ballActive = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One frame: startOfFrame on its first pixel, ball overlapping the holes in
   // mask for the first ov pixels (the startOfFrame pixel included).
   task automatic send_frame(input logic [5:0] mask, input int ov, input int len);
      for (int p = 0; p < len; p++) begin
         startOfFrame       = (p == 0);
         drawingRequestBall = (p < ov);
         drawingRequestHole = (p < ov) ? mask : 6'b0;
         tick();
      end
      idle_inputs();
   endtask

   // Lone startOfFrame with no overlap: closes the previous frame.
   task automatic sof_pulse();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      ballActive = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (pocketReq !== 1'b0) begin
         errors++;
         $display("FAIL reset_req: got %b expected 0", pocketReq);
      end
      checks++;
      if (pocketHole !== 3'd0) begin
         errors++;
         $display("FAIL reset_hole: got %0d expected 0", pocketHole);
      end
      checks++;
      if (dut.state_q !== TRACK) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dut.state_q, TRACK);
      end
   endtask

   task automatic test_defaults();
      do_reset();
      send_frame(6'b000100, 100, 120);
      send_frame(6'b000100, 100, 120);
      checks++;
      if (pocketReq !== 1'b0) begin
         errors++;
         $display("FAIL default_early: pocketReq got %b expected 0", pocketReq);
      end
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b1 || pocketHole !== 3'd2) begin
         errors++;
         $display("FAIL default_report: req/hole got %b/%0d expected 1/2", pocketReq, pocketHole);
      end
      // A frame overlapping another hole must not disturb the pending event.
      send_frame(6'b000001, 100, 110);
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b1 || pocketHole !== 3'd2) begin
         errors++;
         $display("FAIL default_hold: req/hole got %b/%0d expected 1/2", pocketReq, pocketHole);
      end
      pocketAck = 1'b1;
      tick();
      pocketAck = 1'b0;
      checks++;
      if (pocketReq !== 1'b0 || pocketHole !== 3'd0) begin
         errors++;
         $display("FAIL default_ack: req/hole got %b/%0d expected 0/0", pocketReq, pocketHole);
      end
   endtask

   task automatic test_threshold();
      do_reset();
      for (int f = 0; f < 5; f++) begin
         send_frame(6'b000001, 63, 80);
      end
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b0 || dut.state_q !== TRACK) begin
         errors++;
         $display("FAIL thr_63: req/state got %b/%0d expected 0/%0d", pocketReq, dut.state_q, TRACK);
      end
      send_frame(6'b100000, 64, 80);
      send_frame(6'b100000, 64, 80);
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b1 || pocketHole !== 3'd5) begin
         errors++;
         $display("FAIL thr_64: req/hole got %b/%0d expected 1/5", pocketReq, pocketHole);
      end
   endtask

   task automatic test_switch_tie();
      do_reset();
      send_frame(6'b000010, 80, 90);
      send_frame(6'b011000, 80, 90);
      checks++;
      if (dut.cand_idx_q !== 3'd1 || dut.state_q !== CANDIDATE) begin
         errors++;
         $display("FAIL switch_first: cand/state got %0d/%0d expected 1/%0d", dut.cand_idx_q, dut.state_q, CANDIDATE);
      end
      send_frame(6'b001000, 80, 90);
      checks++;
      if (dut.cand_idx_q !== 3'd3 || dut.confirm_cnt_q !== 3'd1) begin
         errors++;
         $display("FAIL switch_tie: cand/conf got %0d/%0d expected 3/1", dut.cand_idx_q, dut.confirm_cnt_q);
      end
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b1 || pocketHole !== 3'd3) begin
         errors++;
         $display("FAIL switch_report: req/hole got %b/%0d expected 1/3", pocketReq, pocketHole);
      end
   endtask

   task automatic test_handshake();
      do_reset();
      pocketAck = 1'b1;
      tick();
      pocketAck = 1'b0;
      checks++;
      if (pocketReq !== 1'b0 || dut.state_q !== TRACK) begin
         errors++;
         $display("FAIL hs_ack_track: req/state got %b/%0d expected 0/%0d", pocketReq, dut.state_q, TRACK);
      end
      send_frame(6'b000001, 100, 110);
      send_frame(6'b000001, 100, 110);
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b1 || pocketHole !== 3'd0) begin
         errors++;
         $display("FAIL hs_report: req/hole got %b/%0d expected 1/0", pocketReq, pocketHole);
      end
      startOfFrame = 1'b1;
      pocketAck    = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (pocketReq !== 1'b0 || dut.state_q !== WAIT_CLEAR) begin
         errors++;
         $display("FAIL hs_ack_sof: req/state got %b/%0d expected 0/%0d", pocketReq, dut.state_q, WAIT_CLEAR);
      end
      tick();
      tick();
      checks++;
      if (dut.state_q !== WAIT_CLEAR) begin
         errors++;
         $display("FAIL hs_wait: state got %0d expected %0d", dut.state_q, WAIT_CLEAR);
      end
      ballActive = 1'b0;
      tick();
      ballActive = 1'b1;
      checks++;
      if (dut.state_q !== TRACK || pocketReq !== 1'b0) begin
         errors++;
         $display("FAIL hs_clear: state/req got %0d/%b expected %0d/0", dut.state_q, pocketReq, TRACK);
      end
   endtask

   task automatic test_reset_mid_report();
      do_reset();
      send_frame(6'b010000, 100, 110);
      send_frame(6'b010000, 100, 110);
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b1 || pocketHole !== 3'd4) begin
         errors++;
         $display("FAIL rst_pre: req/hole got %b/%0d expected 1/4", pocketReq, pocketHole);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (pocketReq !== 1'b0 || pocketHole !== 3'd0) begin
         errors++;
         $display("FAIL rst_drop: req/hole got %b/%0d expected 0/0", pocketReq, pocketHole);
      end
      send_frame(6'b010000, 0, 50);
      sof_pulse();
      checks++;
      if (pocketReq !== 1'b0 || dut.state_q !== TRACK) begin
         errors++;
         $display("FAIL rst_after: req/state got %b/%0d expected 0/%0d", pocketReq, dut.state_q, TRACK);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      send_frame(6'b000001, 3000, 3010);
      sof_pulse();
      checks++;
      if (dut.g_hole[0].u_cnt.snap_q !== 11'd2047) begin
         errors++;
         $display("FAIL sat_snap: got %0d expected 2047", dut.g_hole[0].u_cnt.snap_q);
      end
      checks++;
      if (dut.g_hole[1].u_cnt.snap_q !== 11'd0) begin
         errors++;
         $display("FAIL sat_other: got %0d expected 0", dut.g_hole[1].u_cnt.snap_q);
      end
   endtask

   initial begin
      reset = 1'b1;
      ballActive = 1'b0;
      idle_inputs();
      test_reset();
      test_defaults();
      test_threshold();
      test_switch_tie();
      test_handshake();
      test_reset_mid_report();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
